// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_pkg;
   localparam int DEF_ADDR_W     = 32;
   localparam int DEF_LINE_WORDS = 4;
   localparam int DEF_NUM_LINES  = 16;

   localparam int OFF_W = $clog2(DEF_LINE_WORDS);
   localparam int IDX_W = $clog2(DEF_NUM_LINES);
   localparam int TAG_W = DEF_ADDR_W - OFF_W - IDX_W - 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOOKUP  = 2'd1,
      REFILL  = 2'd2,
      RESPOND = 2'd3
   } state_t;
endpackage

// File: rtl/icache_store.sv
// Line storage: data words with a combinational read port, tags, and valid bits.
// Writes land at the clock edge; valid bulk-clear takes priority over a set.
module icache_store
   import icache_pkg::*;
#(
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int NUM_LINES  = DEF_NUM_LINES,
   parameter int TW         = TAG_W
)(
   input  logic                          clk,
   input  logic [$clog2(NUM_LINES)-1:0]  i_rd_idx,
   input  logic [$clog2(LINE_WORDS)-1:0] i_rd_off,
   output logic [31:0]                   o_rd_dat,
   output logic [TW-1:0]                 o_rd_tag,
   output logic                          o_rd_vld,
   input  logic [$clog2(NUM_LINES)-1:0]  i_wr_idx,
   input  logic [$clog2(LINE_WORDS)-1:0] i_wr_off,
   input  logic                          i_wr_en,
   input  logic [31:0]                   i_wr_dat,
   input  logic                          i_tag_we,
   input  logic [TW-1:0]                 i_tag_dat,
   input  logic                          i_vld_set,
   input  logic                          i_clr
);
   logic [31:0]          r_data [NUM_LINES*LINE_WORDS];
   logic [TW-1:0]        r_tag  [NUM_LINES];
   logic [NUM_LINES-1:0] r_valid;

   assign o_rd_dat = r_data[{i_rd_idx, i_rd_off}];
   assign o_rd_tag = r_tag[i_rd_idx];
   assign o_rd_vld = r_valid[i_rd_idx];

   always_ff @(posedge clk) begin
      if (i_wr_en)
         r_data[{i_wr_idx, i_wr_off}] <= i_wr_dat;
      if (i_tag_we)
         r_tag[i_wr_idx] <= i_tag_dat;
   end

   always_ff @(posedge clk) begin
      if (i_clr)
         r_valid <= '0;
      else if (i_vld_set)
         r_valid[i_wr_idx] <= 1'b1;
   end
endmodule

// File: rtl/icache.sv
// Direct-mapped read-only I-cache: hit answers 2 cycles after req, miss refills a line beat by beat.
// No backpressure on the core side; memory beats stall on mem_rvalid. ICACHE_STATS_EN adds hit/miss counters.
module icache
   import icache_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int NUM_LINES  = DEF_NUM_LINES
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic [ADDR_W-1:0] addr,
   output logic              ready,
   output logic [31:0]       instr,
   input  logic              flush,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
`endif
);
   localparam int OW = $clog2(LINE_WORDS);
   localparam int IW = $clog2(NUM_LINES);
   localparam int TW = ADDR_W - OW - IW - 2;

   state_t              r_state;
   logic [ADDR_W-1:2]   r_addr;
   logic [OW-1:0]       r_beat;
   logic                r_done;
   logic                r_flushed;
   logic [31:0]         r_instr;

   logic [OW-1:0]       w_off;
   logic [IW-1:0]       w_idx;
   logic [TW-1:0]       w_tag;
   logic [31:0]         w_rd_dat;
   logic [TW-1:0]       w_rd_tag;
   logic                w_rd_vld;
   logic                w_hit;
   logic                w_beat_wr;
   logic                w_fill_done;
   logic                w_unused;

   assign w_unused    = &{1'b0, addr[1:0]};
   assign w_off       = r_addr[OW+1:2];
   assign w_idx       = r_addr[OW+IW+1:OW+2];
   assign w_tag       = r_addr[ADDR_W-1:OW+IW+2];
   assign w_hit       = w_rd_vld && (w_rd_tag == w_tag);
   assign w_beat_wr   = (r_state == REFILL) && !r_done && mem_rvalid;
   // One extra cycle after the last beat commits tag/valid with mem_req already low.
   assign w_fill_done = (r_state == REFILL) && r_done;

   assign ready    = (r_state == RESPOND);
   assign instr    = r_instr;
   assign mem_req  = (r_state == REFILL) && !r_done;
   assign mem_addr = {r_addr[ADDR_W-1:OW+2], r_beat, 2'b00};

   icache_store #(
      .LINE_WORDS (LINE_WORDS),
      .NUM_LINES  (NUM_LINES),
      .TW         (TW)
   ) u_store (
      .clk       (clk),
      .i_rd_idx  (w_idx),
      .i_rd_off  (w_off),
      .o_rd_dat  (w_rd_dat),
      .o_rd_tag  (w_rd_tag),
      .o_rd_vld  (w_rd_vld),
      .i_wr_idx  (w_idx),
      .i_wr_off  (r_beat),
      .i_wr_en   (w_beat_wr),
      .i_wr_dat  (mem_rdata),
      .i_tag_we  (w_fill_done),
      .i_tag_dat (w_tag),
      .i_vld_set (w_fill_done && !r_flushed),
      .i_clr     (!reset || flush)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_beat    <= '0;
         r_done    <= 1'b0;
         r_flushed <= 1'b0;
         r_instr   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req) begin
                  r_addr  <= addr[ADDR_W-1:2];
                  r_state <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (w_hit) begin
                  r_instr <= w_rd_dat;
                  r_state <= RESPOND;
               end else begin
                  r_beat    <= '0;
                  r_done    <= 1'b0;
                  r_flushed <= 1'b0;
                  r_state   <= REFILL;
               end
            end
            REFILL: begin
               if (flush)
                  r_flushed <= 1'b1;
               if (r_done) begin
                  r_state <= RESPOND;
               end else if (mem_rvalid) begin
                  if (r_beat == w_off)
                     r_instr <= mem_rdata;
                  if (&r_beat)
                     r_done <= 1'b1;
                  r_beat <= r_beat + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (r_state == LOOKUP) begin
         if (w_hit)
            r_hit_cnt <= r_hit_cnt + 32'd1;
         else
            r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   assign hit_count  = r_hit_cnt;
   assign miss_count = r_miss_cnt;
`endif
endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: expected instr words and refill addresses are queued by stimulus, popped by monitors.
module tb_icache;
   logic        clk;
   logic        reset;
   logic        req;
   logic [31:0] addr;
   logic        ready;
   logic [31:0] instr;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_ma[$];
   logic [7:0]  gen = 8'd0;
   int          mem_lat = 1;
   int          beats = 0;
   logic        prev_ready = 1'b0;

   icache dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .addr       (addr),
      .ready      (ready),
      .instr      (instr),
      .flush      (flush),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Memory model: rvalid in the L-th cycle of each beat, data tagged with the current generation.
   initial begin
      int lat_cnt;
      lat_cnt    = 0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_rvalid) begin
            mem_rvalid = 1'b0;
            lat_cnt    = 0;
         end
         if (mem_req) begin
            lat_cnt++;
            if (lat_cnt >= mem_lat) begin
               mem_rvalid = 1'b1;
               mem_rdata  = {gen, 8'hD0, mem_addr[15:0]};
               beats++;
               if (exp_ma.size() == 0)
                  chk("unexpected_beat", mem_addr, 32'hFFFF_FFFF);
               else
                  chk("mem_addr", mem_addr, exp_ma.pop_front());
            end
         end else begin
            lat_cnt = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (ready) begin
         if (exp_q.size() == 0)
            chk("unexpected_ready", instr, 32'hFFFF_FFFF);
         else
            chk("instr", instr, exp_q.pop_front());
         if (prev_ready)
            chk("ready_twice", 32'd1, 32'd0);
      end
      prev_ready = ready;
   end

   task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input int exp_cyc,
                        input int exp_beats, input int flush_at);
      int cyc;
      int b0;
      exp_q.push_back(exp);
      for (int i = 0; i < exp_beats; i++)
         exp_ma.push_back({a[31:4], 2'(i), 2'b00});
      b0 = beats;
      @(negedge clk);
      req  = 1'b1;
      addr = a;
      @(negedge clk);
      req = 1'b0;
      cyc = 1;
      while (!ready && cyc < 60) begin
         @(negedge clk);
         cyc++;
         flush = (cyc == flush_at);
      end
      flush = 1'b0;
      chk($sformatf("latency@%h", a), 32'(cyc), 32'(exp_cyc));
      chk($sformatf("beats@%h", a), 32'(beats - b0), 32'(exp_beats));
   endtask

   initial begin
      int rdy_cnt;
      reset = 1'b0;
      req   = 1'b0;
      addr  = '0;
      flush = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      reset = 1'b1;

      gen = 8'd1;
      fetch(32'h0000_0104, 32'h01D0_0104, 7, 4, 0);   // cold miss
      fetch(32'h0000_0108, 32'h01D0_0108, 2, 0, 0);   // hit
      fetch(32'h0000_010C, 32'h01D0_010C, 2, 0, 0);
      gen = 8'd2;
      fetch(32'h0000_0300, 32'h02D0_0300, 7, 4, 0);   // conflict eviction
      gen = 8'd3;
      fetch(32'h0000_0100, 32'h03D0_0100, 7, 4, 0);

      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      gen = 8'd4;
      fetch(32'h0000_0104, 32'h04D0_0104, 7, 4, 0);   // miss after flush

      gen = 8'd5;
      fetch(32'h0000_0208, 32'h05D0_0208, 7, 4, 4);   // flush on beat 2
      gen = 8'd6;
      fetch(32'h0000_0208, 32'h06D0_0208, 7, 4, 0);
      gen = 8'd7;
      fetch(32'h0000_0404, 32'h07D0_0404, 7, 4, 6);   // flush with final valid write
      gen = 8'd8;
      fetch(32'h0000_0404, 32'h08D0_0404, 7, 4, 0);

      gen = 8'd9;
      mem_lat = 2;
      fetch(32'h0000_1234, 32'h09D0_1234, 11, 4, 0);
      mem_lat = 1;
      fetch(32'h0000_1238, 32'h09D0_1238, 2, 0, 0);
      gen = 8'd10;
      fetch(32'h8000_1234, 32'h0AD0_1234, 7, 4, 0);   // tag differs only in top bit

      exp_ma.push_back(32'h0000_0A00);
      exp_ma.push_back(32'h0000_0A04);
      @(negedge clk);
      req  = 1'b1;
      addr = 32'h0000_0A00;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("midrst_instr", instr, 32'd0);
`ifdef ICACHE_STATS_EN
      chk("rst_hit_count", hit_count, 32'd0);
      chk("rst_miss_count", miss_count, 32'd0);
`endif
      rdy_cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (ready) rdy_cnt++;
      end
      chk("midrst_no_ready", 32'(rdy_cnt), 32'd0);

      gen = 8'd11;
      fetch(32'h0000_0100, 32'h0BD0_0100, 7, 4, 0);
      fetch(32'h0000_0104, 32'h0BD0_0104, 2, 0, 0);
      gen = 8'd12;
      fetch(32'h0000_0500, 32'h0CD0_0500, 7, 4, 0);
      gen = 8'd13;
      fetch(32'h0000_0600, 32'h0DD0_0600, 7, 4, 0);
      fetch(32'h0000_0604, 32'h0DD0_0604, 2, 0, 0);
`ifdef ICACHE_STATS_EN
      chk("hit_count", hit_count, 32'd2);
      chk("miss_count", miss_count, 32'd3);
`endif

      repeat (3) @(negedge clk);
      chk("instr_queue_left", 32'(exp_q.size()), 32'd0);
      chk("addr_queue_left", 32'(exp_ma.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the core's control FSM and the memory interface. It accepts a single-cycle fetch request from the FETCH_INSTR state and returns the instruction with a one-cycle `ready` pulse, which the WAIT_INSTR state consumes. On a miss it refills a whole line through a simple one-beat-per-request memory handshake. It also supports whole-cache invalidation for fence/flush.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width.
- `LINE_WORDS`, 4: 32-bit words per line; power of two, ≥2.
- `NUM_LINES`, 16: number of lines; power of two, ≥2.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-low.
- `req`  in  1: fetch request, one-cycle pulse, sampled only in IDLE.
- `addr`  in  ADDR_W: fetch byte address, valid with `req`.
- `ready`  out  1: one-cycle pulse; `instr` is valid in the same cycle.
- `instr`  out  32: fetched word; holds its value until the next `ready`.
- `flush`  in  1: invalidate all lines.
- `mem_req`  out  1: memory read request, held until `mem_rvalid`.
- `mem_addr`  out  ADDR_W: word-aligned read address; stable while `mem_req` is high.
- `mem_rvalid`  in  1: read data valid; completes the current beat.
- `mem_rdata`  in  32: read data.
- `hit_count`, `miss_count`  out  32 each: present only with ICACHE_STATS_EN.

## Operation
- Address split:
  - bits [1:0] are ignored.
  - offset = [OFF_W+1:2], where OFF_W = log2(LINE_WORDS).
  - index = next log2(NUM_LINES) bits.
  - tag = the remaining upper bits.
- State machine states: IDLE, LOOKUP, REFILL, RESPOND.
- IDLE:
  - When `req` = 1, register `addr` and go to LOOKUP.
  - A `req` arriving in any other state is ignored.
- LOOKUP:
  - Hit (valid[index] and tag match): register the stored word at the offset into `instr`, go to RESPOND.
  - Miss: clear the beat counter, go to REFILL.
- REFILL:
  - `mem_req` = 1 and `mem_addr` = {tag, index, beat, 2'b00}; beats run from 0 to LINE_WORDS-1 in order.
  - On each `mem_rvalid`, write `mem_rdata` into the line. If beat == offset, also capture it into `instr`. Then increment the beat.
  - After the last beat, write the tag, set valid (subject to the flush rule below), and go to RESPOND.
  - `mem_rvalid` is ignored outside REFILL.
- RESPOND: `ready` = 1 for exactly this cycle, then go to IDLE.
- Flush:
  - Asserting `flush` clears all valid bits at the next edge, in any state.
  - If `flush` occurs while in REFILL, the refill completes and the response is delivered, but the line is not marked valid.
  - If `flush` and the final-beat valid write coincide, the line stays invalid.
- Reset:
  - Clears all valid bits and returns the state to IDLE.
  - `ready`, `mem_req` and `instr` go to 0.
  - Line data and tags are don't-care after reset.
  - A reset in mid-refill abandons the refill; `mem_req` drops on the next cycle.

## Timing
- Request in cycle N:
  - Hit: LOOKUP in N+1, `ready` in N+2.
  - Miss: `mem_req` is first high in N+2. With memory latency L cycles per beat (`mem_rvalid` L cycles after the beat starts, L ≥ 1), `ready` occurs in N+2+LINE_WORDS·L+1.
- The next beat's request starts in the cycle after `mem_rvalid`, with `mem_addr` already updated.
- `ready` is never high in two consecutive cycles.
- The earliest new `req` accepted is the cycle after `ready`.

## Configuration
- `ICACHE_STATS_EN`:
  - Defined: adds `hit_count` and `miss_count`. Each increments by 1 on a LOOKUP hit or miss respectively, wraps at 2^32, and resets to 0. Flush does not clear them.
  - Undefined: the counters and ports are absent; behaviour is otherwise identical.

## Structure
- `icache_pkg` contains:
  - The state enum (IDLE, LOOKUP, REFILL, RESPOND).
  - Default parameter values.
  - Derived-width localparams: OFF_W, IDX_W, TAG_W.
- Sub-module `icache_store`:
  - Data array (NUM_LINES·LINE_WORDS × 32) with a combinational read port and a single write port.
  - Tag array.
  - Valid vector with a bulk-clear input.
- The FSM, counters and handshake logic stay in `icache`.

## Test plan
- Cold miss: reset, then `req` with `addr`=0x0000_0104 and L=1 → four `mem_req` beats at 0x100, 0x104, 0x108, 0x10C; `ready` in N+7; `instr` = beat-1 data.
- Hit: repeat `addr`=0x0000_0108 → no `mem_req`; `ready` in N+2; `instr` = beat-2 data.
- Conflict eviction: `addr` 0x100 then 0x200+0x100 (same index, different tag) → second access misses and refills; a later 0x100 misses again.
- Flush: `flush` pulse after a fill, then `req` 0x100 → miss with a full refill.
- Flush during refill: `flush` on beat 2 → `ready` still delivered with correct `instr`; an immediate repeat `req` misses.
- Reset mid-refill, plus stats: `reset` low during beat 1 → `mem_req` low the next cycle and `ready` never pulses. With ICACHE_STATS_EN, 3 misses + 2 hits give `hit_count`=2 and `miss_count`=3.
